// File: rtl/seg7_scan_if.sv
// Signal bundle between the segment converter / display pins and the seg7_scan driver.
// The master side supplies patterns and controls; the slave side (the driver) returns the display drive.
interface seg7_scan_if;
  logic [6:0] un;
  logic [6:0] dec;
  logic [6:0] cent;
  logic [6:0] mil;
  logic       en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  modport master (
    output un, dec, cent, mil, en, blank_lz,
    input  an, seg, frame_tick
  );

  modport slave (
    input  un, dec, cent, mil, en, blank_lz,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit common-anode scan driver: per-frame snapshot of the digit patterns,
// programmable dwell per digit, leading dead time against ghosting, optional leading-zero blanking.
module seg7_scan #(
  parameter int         DIV       = 50000,
  parameter int         DEAD      = 16,
  parameter logic [6:0] ZERO_CODE = 7'b1000000
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [6:0]    snap [4];
  logic [3:0]    lz;
  logic [3:0]    an_on;
  logic          dead_phase;
  logic          snap_edge;
  logic          blank;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          tick_q;

  // With no dead time the comparison would be against zero, so it is elided entirely.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign dead_phase = 1'b0;
    end else begin : g_dead
      assign dead_phase = (cnt < CW'(DEAD));
    end
  endgenerate

  always_comb begin
    lz        = 4'b0000;
    lz[3]     = (snap[3] == ZERO_CODE);
    lz[2]     = lz[3] && (snap[2] == ZERO_CODE);
    lz[1]     = lz[2] && (snap[1] == ZERO_CODE);
    snap_edge = (cnt == '0) && (dig == 2'd0);
    an_on     = 4'b0001 << dig;
    blank     = !bus.en || dead_phase || (bus.blank_lz && lz[dig]);
  end

  // Outputs are computed from the pre-edge scan state, so snap is still the previous frame's on the snapshot edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dig    <= 2'd0;
      for (int i = 0; i < 4; i++) snap[i] <= 7'h7F;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      tick_q <= 1'b0;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      tick_q <= snap_edge;
      if (snap_edge) begin
        snap[0] <= bus.un;
        snap[1] <= bus.dec;
        snap[2] <= bus.cent;
        snap[3] <= bus.mil;
      end

      if (blank) begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
      end else begin
        an_q  <= ~an_on;
        seg_q <= snap[dig];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIV=8, DEAD=2): directed scenarios plus random traffic,
// compared each cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan;

  localparam int         DIV   = 8;
  localparam int         DEAD  = 2;
  localparam int         FRAME = 4 * DIV;
  localparam logic [6:0] ZC    = 7'b1000000;

  logic clk;
  logic rst;
  seg7_scan_if bus ();

  seg7_scan #(.DIV(DIV), .DEAD(DEAD), .ZERO_CODE(ZC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release and the patterns latched at the last frame start.
  int         edges;
  logic [6:0] m_snap [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_ft;

  function automatic bit lz_of(int d);
    if (d == 0) return 1'b0;
    for (int j = d; j < 4; j++)
      if (m_snap[j] != ZC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] rand_pat();
    if ($urandom_range(2) == 0) return ZC;
    return 7'($urandom);
  endfunction

  function automatic int slot_pos();
    return edges % FRAME;
  endfunction

  task automatic applyStimulus(input logic [6:0] u, d, c, m, input logic e, lzb);
    bus.un       = u;
    bus.dec      = d;
    bus.cent     = c;
    bus.mil      = m;
    bus.en       = e;
    bus.blank_lz = lzb;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (bus.an === exp_an) else begin
      errors++;
      $error("[TB] FAIL %s an: got %b want %b", tag, bus.an, exp_an);
    end
    checks++;
    assert (bus.seg === exp_seg) else begin
      errors++;
      $error("[TB] FAIL %s seg: got %h want %h", tag, bus.seg, exp_seg);
    end
    checks++;
    assert (bus.frame_tick === exp_ft) else begin
      errors++;
      $error("[TB] FAIL %s frame_tick: got %b want %b", tag, bus.frame_tick, exp_ft);
    end
    checks++;
    assert ($countones(~bus.an) <= 1) else begin
      errors++;
      $error("[TB] FAIL %s overlap: got an=%b want at most one low", tag, bus.an);
    end
  endtask

  // One clock: evaluate the model from the values present at the edge, then check shortly after.
  task automatic step(input string tag);
    int p, d, c;
    @(posedge clk);
    if (rst) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_ft  = 1'b0;
      edges   = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
    end else begin
      p = slot_pos();
      d = p / DIV;
      c = p % DIV;
      exp_ft = (p == 0);
      if (!bus.en || c < DEAD || (bus.blank_lz && lz_of(d))) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = m_snap[d];
      end
      if (p == 0) begin
        m_snap[0] = bus.un;
        m_snap[1] = bus.dec;
        m_snap[2] = bus.cent;
        m_snap[3] = bus.mil;
      end
      edges++;
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Advance until the next edge falls in the given frame position range (bounded to one frame).
  task automatic seek(input string tag, input int lo, input int hi);
    for (int i = 0; i < FRAME; i++) begin
      if (slot_pos() >= lo && slot_pos() <= hi) return;
      step(tag);
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s seek: got position %0d want %0d..%0d", tag, slot_pos(), lo, hi);
  endtask

  initial begin
    edges = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;

    rst = 1'b1;
    applyStimulus(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0);
    run("reset", 3);

    $display("[TB] basic scan");
    rst = 1'b0;
    step("basic_first");
    checks++;
    assert (bus.frame_tick === 1'b1 && bus.an === 4'hF) else begin
      errors++;
      $error("[TB] FAIL basic_tick: got ft=%b an=%b want ft=1 an=1111", bus.frame_tick, bus.an);
    end
    run("basic", 2 * FRAME - 1);

    $display("[TB] leading-zero blanking");
    applyStimulus(7'h79, 7'h24, ZC, ZC, 1'b1, 1'b1);
    run("lz2", 2 * FRAME);
    bus.dec = ZC;
    run("lz3", 2 * FRAME);
    bus.un = ZC;
    run("lz_all", 2 * FRAME);
    bus.blank_lz = 1'b0;
    run("lz_off", FRAME);

    $display("[TB] snapshot isolation");
    applyStimulus(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0);
    seek("iso_seek", 0, 0);
    run("iso_load", DIV + 3);
    bus.un = 7'h12;
    run("iso", 2 * FRAME);

    $display("[TB] enable");
    seek("en_seek", DIV + 4, DIV + 4);
    bus.en = 1'b0;
    run("en_off", 10);
    bus.en = 1'b1;
    run("en_on", FRAME);

    $display("[TB] mid-frame reset");
    seek("rst_seek", 2 * DIV + 3, 2 * DIV + 3);
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    run("rst_restart", FRAME + DIV);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0)
        applyStimulus(rand_pat(), rand_pat(), rand_pat(), rand_pat(),
                      ($urandom_range(7) != 0), 1'($urandom));
      rst = ($urandom_range(99) == 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
